star_scheduler: RTL and testbench
=================================

STAR_SCHEDULER -- requirements
Module: star_scheduler

Interface
REQ-001 Parameter NUM_STARS, default 8, number of collectible star slots (power of two, 2..16).
REQ-002 Parameter STAR_SIZE, default 12, bounding-box edge length in pixels for both character and star.
REQ-003 sys_clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 frame_tick  in  1  one-cycle pulse; starts one collision scan.
REQ-006 level_reset  in  1  synchronous pulse; re-arms all stars.
REQ-007 char_X, char_Y  in  10 each  character top-left, world coordinates.
REQ-008 bg_pos  in  10  horizontal scroll offset.
REQ-009 rd_idx  in  log2(NUM_STARS)  render-side slot select.
REQ-010 rd_x, rd_y  out  10 each  selected star screen position (combinational).
REQ-011 rd_en  out  1  selected star still visible (combinational).
REQ-012 star_mask  out  NUM_STARS  per-slot visible bit.
REQ-013 collect_pulse  out  1  one-cycle pulse when a star is collected.
REQ-014 collect_idx  out  log2(NUM_STARS)  slot collected; valid only with collect_pulse.
REQ-015 star_count  out  log2(NUM_STARS)+1  stars collected since last re-arm.
REQ-016 all_collected  out  1  high while star_mask is all zero.
REQ-017 busy  out  1  high while a scan is in progress.

Function
REQ-018 FSM states IDLE and SCAN; IDLE->SCAN on frame_tick; SCAN->IDLE after evaluating the last slot.
REQ-019 On an accepted frame_tick, char_X and char_Y are latched; the scan uses only the latched values.
REQ-020 Tick accepted at edge k: slot i is evaluated at edge k+1+i; busy is high for exactly NUM_STARS cycles.
REQ-021 frame_tick while busy is ignored, with no restart and no queuing.
REQ-022 Hit condition uses 11-bit unsigned arithmetic: cx <= sx+STAR_SIZE AND cx+STAR_SIZE >= sx, same for y; edges inclusive; no wrap.
REQ-023 A hit on a visible slot clears its star_mask bit, increments star_count, and drives collect_pulse=1 with collect_idx=i in the following cycle only.
REQ-024 Hits on already-cleared slots produce no pulse and no count change.
REQ-025 rd_x = star world x minus bg_pos, modulo 2^10; rd_y = star world y; rd_en = star_mask[rd_idx].
REQ-026 level_reset has highest priority: mask all ones, star_count 0, FSM to IDLE, collect_pulse 0 at the next edge; a coincident frame_tick is dropped.
REQ-027 level_reset mid-scan aborts the scan; remaining slots are not evaluated.

Reset
REQ-028 RST_N low asynchronously sets star_mask all ones, star_count 0, collect_pulse 0, collect_idx 0, busy 0, FSM IDLE, and the latched character position to 0.
REQ-029 After RST_N deasserts, the first frame_tick is accepted on the first rising edge.

Structure
REQ-030 A shared package holds the star world-position table (slot 0 = (236,200), slot 1 = (300,180), others fixed there), STAR_SIZE default, and FSM state encoding.
REQ-031 One combinational sub-module, star_hit_check, implements REQ-022 and is instantiated once, shared across slots by the scan index.

Verification
REQ-032 Reset -> star_mask=0xFF, star_count=0, busy=0, all_collected=0, collect_pulse=0.
REQ-033 char=(240,205), tick at edge k -> collect_pulse=1, collect_idx=0 in the cycle after edge k+1; mask=0xFE; count=1; repeat tick -> no pulse.
REQ-034 Boundary: char=(224,188) -> slot 0 hit; char=(223,200) -> no hit; char=(248,212) -> hit; char=(249,200) -> no hit.
REQ-035 Tick at edge k, second tick at k+3 -> busy stays high for 8 cycles only, one scan.
REQ-036 level_reset at scan slot 3 -> busy=0 and mask=0xFF next cycle; no pulses afterwards.
REQ-037 bg_pos=36, rd_idx=0 -> rd_x=200, rd_y=200; bg_pos=300 -> rd_x=960 (wrap).

Source files
------------

// File: rtl/star_scheduler_pkg.sv
// Shared definitions for the star scheduler: fixed star world positions,
// default bounding-box size and the scan FSM encoding.
package star_scheduler_pkg;

    localparam int STAR_SIZE_DEF = 12;
    localparam int MAX_STARS     = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // World-coordinate top-left corner of each star slot; builds with fewer
    // slots use only the leading entries.
    localparam logic [9:0] STAR_X [MAX_STARS] = '{
        10'd236, 10'd300, 10'd400, 10'd500, 10'd600, 10'd700, 10'd800, 10'd900,
        10'd100, 10'd150, 10'd350, 10'd450, 10'd550, 10'd650, 10'd750, 10'd850
    };
    localparam logic [9:0] STAR_Y [MAX_STARS] = '{
        10'd200, 10'd180, 10'd100, 10'd300, 10'd50,  10'd400, 10'd250, 10'd150,
        10'd600, 10'd650, 10'd700, 10'd500, 10'd550, 10'd620, 10'd680, 10'd720
    };

    function automatic logic [9:0] star_x(input logic [3:0] idx);
        return STAR_X[idx];
    endfunction

    function automatic logic [9:0] star_y(input logic [3:0] idx);
        return STAR_Y[idx];
    endfunction

endpackage

// File: rtl/star_scheduler_hit_check.sv
// Axis-aligned box overlap test between character and one star, with
// inclusive edges; sums are carried in 11 bits so they never wrap.
module star_hit_check #(
    parameter int STAR_SIZE = 12
) (
    input  logic [9:0] cx_i,
    input  logic [9:0] cy_i,
    input  logic [9:0] sx_i,
    input  logic [9:0] sy_i,
    output logic       hit_o
);

    localparam logic [10:0] SZ = 11'(STAR_SIZE);

    logic [10:0] cx, cy, sx, sy;
    logic        hit_x, hit_y;

    assign cx = {1'b0, cx_i};
    assign cy = {1'b0, cy_i};
    assign sx = {1'b0, sx_i};
    assign sy = {1'b0, sy_i};

    assign hit_x = (cx <= sx + SZ) && (cx + SZ >= sx);
    assign hit_y = (cy <= sy + SZ) && (cy + SZ >= sy);
    assign hit_o = hit_x && hit_y;

endmodule

// File: rtl/star_scheduler.sv
// Star collection scheduler: one slot per cycle is checked against the
// character position latched at frame_tick; collected slots drop out of the mask.
module star_scheduler
    import star_scheduler_pkg::*;
#(
    parameter int NUM_STARS = 8,
    parameter int STAR_SIZE = STAR_SIZE_DEF
) (
    input  logic                           sys_clk,
    input  logic                           RST_N,
    input  logic                           frame_tick,
    input  logic                           level_reset,
    input  logic [9:0]                     char_X,
    input  logic [9:0]                     char_Y,
    input  logic [9:0]                     bg_pos,
    input  logic [$clog2(NUM_STARS)-1:0]   rd_idx,
    output logic [9:0]                     rd_x,
    output logic [9:0]                     rd_y,
    output logic                           rd_en,
    output logic [NUM_STARS-1:0]           star_mask,
    output logic                           collect_pulse,
    output logic [$clog2(NUM_STARS)-1:0]   collect_idx,
    output logic [$clog2(NUM_STARS):0]     star_count,
    output logic                           all_collected,
    output logic                           busy
);

    localparam int IW = $clog2(NUM_STARS);
    localparam int CW = IW + 1;

    state_e               state_q, state_d;
    logic [IW-1:0]        scan_idx_q, scan_idx_d;
    logic [NUM_STARS-1:0] mask_q, mask_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 pulse_q, pulse_d;
    logic [IW-1:0]        cidx_q, cidx_d;
    logic [9:0]           cx_q, cx_d;
    logic [9:0]           cy_q, cy_d;
    logic                 hit;

    star_hit_check #(
        .STAR_SIZE (STAR_SIZE)
    ) u_hit (
        .cx_i  (cx_q),
        .cy_i  (cy_q),
        .sx_i  (star_x(4'(scan_idx_q))),
        .sy_i  (star_y(4'(scan_idx_q))),
        .hit_o (hit)
    );

    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            scan_idx_q <= '0;
            mask_q     <= '1;
            count_q    <= '0;
            pulse_q    <= 1'b0;
            cidx_q     <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
        end else begin
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            mask_q     <= mask_d;
            count_q    <= count_d;
            pulse_q    <= pulse_d;
            cidx_q     <= cidx_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        mask_d     = mask_q;
        count_d    = count_q;
        pulse_d    = 1'b0;
        cidx_d     = cidx_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        // level_reset overrides everything, including a scan in flight
        if (level_reset) begin
            state_d    = ST_IDLE;
            scan_idx_d = '0;
            mask_d     = '1;
            count_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_tick) begin
                        state_d    = ST_SCAN;
                        scan_idx_d = '0;
                        cx_d       = char_X;
                        cy_d       = char_Y;
                    end
                end
                ST_SCAN: begin
                    if (hit && mask_q[scan_idx_q]) begin
                        mask_d[scan_idx_q] = 1'b0;
                        count_d            = count_q + CW'(1);
                        pulse_d            = 1'b1;
                        cidx_d             = scan_idx_q;
                    end
                    if (scan_idx_q == IW'(NUM_STARS - 1)) begin
                        state_d    = ST_IDLE;
                        scan_idx_d = '0;
                    end else begin
                        scan_idx_d = scan_idx_q + IW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign rd_x          = star_x(4'(rd_idx)) - bg_pos;
    assign rd_y          = star_y(4'(rd_idx));
    assign rd_en         = mask_q[rd_idx];
    assign star_mask     = mask_q;
    assign collect_pulse = pulse_q;
    assign collect_idx   = cidx_q;
    assign star_count    = count_q;
    assign all_collected = (mask_q == '0);
    assign busy          = (state_q == ST_SCAN);

endmodule

// File: tb/tb_star_scheduler.sv
// Directed bench for star_scheduler: vector table of single scans plus
// hand-written sequences for reset, tick overlap, abort and full collection.
module tb_star_scheduler;

    localparam int N = 8;

    logic         sys_clk;
    logic         RST_N;
    logic         frame_tick;
    logic         level_reset;
    logic [9:0]   char_X, char_Y, bg_pos;
    logic [2:0]   rd_idx;
    logic [9:0]   rd_x, rd_y;
    logic         rd_en;
    logic [7:0]   star_mask;
    logic         collect_pulse;
    logic [2:0]   collect_idx;
    logic [3:0]   star_count;
    logic         all_collected;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    star_scheduler #(.NUM_STARS(N), .STAR_SIZE(12)) dut (
        .sys_clk       (sys_clk),
        .RST_N         (RST_N),
        .frame_tick    (frame_tick),
        .level_reset   (level_reset),
        .char_X        (char_X),
        .char_Y        (char_Y),
        .bg_pos        (bg_pos),
        .rd_idx        (rd_idx),
        .rd_x          (rd_x),
        .rd_y          (rd_y),
        .rd_en         (rd_en),
        .star_mask     (star_mask),
        .collect_pulse (collect_pulse),
        .collect_idx   (collect_idx),
        .star_count    (star_count),
        .all_collected (all_collected),
        .busy          (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        logic [9:0] cx;
        logic [9:0] cy;
        int         exp_pulses;
        int         exp_idx;
        logic [7:0] exp_mask;
    } vec_t;

    vec_t vecs[7];

    // Expected star positions for slots 0..7
    int sx_tbl[N] = '{236, 300, 400, 500, 600, 700, 800, 900};
    int sy_tbl[N] = '{200, 180, 100, 300, 50, 400, 250, 150};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_level_reset();
        level_reset = 1'b1;
        step();
        level_reset = 1'b0;
    endtask

    // Tick, then sample for N cycles; pulse seen after edge k+1+j belongs to slot j.
    task automatic run_scan(output int np, output int pslot, output int pidx, output int bc);
        np = 0; pslot = -1; pidx = -1; bc = 0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        if (busy) bc++;
        for (int j = 0; j < N; j++) begin
            step();
            if (collect_pulse) begin
                np++;
                if (pslot < 0) begin
                    pslot = j;
                    pidx  = int'(collect_idx);
                end
            end
            if (busy) bc++;
        end
    endtask

    initial begin
        int np, pslot, pidx, bc;

        vecs[0] = '{10'd240, 10'd205, 1, 0, 8'hFE};
        vecs[1] = '{10'd224, 10'd188, 1, 0, 8'hFE};
        vecs[2] = '{10'd223, 10'd200, 0, -1, 8'hFF};
        vecs[3] = '{10'd248, 10'd212, 1, 0, 8'hFE};
        vecs[4] = '{10'd249, 10'd200, 0, -1, 8'hFF};
        vecs[5] = '{10'd305, 10'd185, 1, 1, 8'hFD};
        vecs[6] = '{10'd0,   10'd0,   0, -1, 8'hFF};

        RST_N = 1'b1; frame_tick = 1'b0; level_reset = 1'b0;
        char_X = 10'd240; char_Y = 10'd205; bg_pos = 10'd0; rd_idx = 3'd0;
        #1 RST_N = 1'b0;
        #7;
        check("reset_mask", int'(star_mask), 8'hFF);
        check("reset_count", int'(star_count), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_all_collected", int'(all_collected), 0);
        check("reset_pulse", int'(collect_pulse), 0);

        // Release between edges with tick already high: first edge must accept it
        frame_tick = 1'b1;
        #4 RST_N = 1'b1;
        step();
        frame_tick = 1'b0;
        check("first_tick_busy", int'(busy), 1);
        check("first_tick_pulse_early", int'(collect_pulse), 0);
        step();
        check("first_tick_pulse", int'(collect_pulse), 1);
        check("first_tick_idx", int'(collect_idx), 0);
        step();
        check("first_tick_pulse_one_cycle", int'(collect_pulse), 0);
        for (int j = 0; j < N - 2; j++) step();
        check("first_scan_done_busy", int'(busy), 0);
        check("first_scan_mask", int'(star_mask), 8'hFE);
        check("first_scan_count", int'(star_count), 1);
        run_scan(np, pslot, pidx, bc);
        check("repeat_tick_pulses", np, 0);
        check("repeat_tick_count", int'(star_count), 1);

        // Render read-out
        rd_idx = 3'd0; bg_pos = 10'd36; #1;
        check("rd_x_bg36", int'(rd_x), 200);
        check("rd_y_slot0", int'(rd_y), 200);
        check("rd_en_collected", int'(rd_en), 0);
        bg_pos = 10'd300; #1;
        check("rd_x_wrap", int'(rd_x), 960);
        rd_idx = 3'd1; bg_pos = 10'd0; #1;
        check("rd_x_slot1", int'(rd_x), 300);
        check("rd_y_slot1", int'(rd_y), 180);
        check("rd_en_slot1", int'(rd_en), 1);

        // Table of single scans from a freshly re-armed level
        for (int v = 0; v < 7; v++) begin
            do_level_reset();
            check($sformatf("v%0d_rearm_mask", v), int'(star_mask), 8'hFF);
            char_X = vecs[v].cx; char_Y = vecs[v].cy;
            run_scan(np, pslot, pidx, bc);
            check($sformatf("v%0d_pulses", v), np, vecs[v].exp_pulses);
            check($sformatf("v%0d_pulse_slot", v), pslot, vecs[v].exp_idx);
            check($sformatf("v%0d_collect_idx", v), pidx, vecs[v].exp_idx);
            check($sformatf("v%0d_busy_cycles", v), bc, N);
            check($sformatf("v%0d_mask", v), int'(star_mask), int'(vecs[v].exp_mask));
            check($sformatf("v%0d_count", v), int'(star_count), vecs[v].exp_pulses);
        end

        // Second tick three cycles into a scan is ignored
        do_level_reset();
        char_X = 10'd240; char_Y = 10'd205;
        bc = 0; np = 0;
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        if (busy) bc++;
        for (int j = 1; j < 14; j++) begin
            if (j == 3) frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (busy) bc++;
            if (collect_pulse) np++;
        end
        check("overlap_busy_cycles", bc, N);
        check("overlap_pulses", np, 1);

        // Abort at slot 3 while the character sits on slot 5
        do_level_reset();
        char_X = 10'd700; char_Y = 10'd400;
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        np = 0;
        for (int j = 0; j < 3; j++) begin
            step();
            if (collect_pulse) np++;
        end
        level_reset = 1'b1; step(); level_reset = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_mask", int'(star_mask), 8'hFF);
        for (int j = 0; j < N + 2; j++) begin
            step();
            if (collect_pulse) np++;
        end
        check("abort_pulses", np, 0);
        check("abort_count", int'(star_count), 0);

        // Tick coincident with level_reset is dropped
        level_reset = 1'b1; frame_tick = 1'b1; step();
        level_reset = 1'b0; frame_tick = 1'b0;
        check("coincident_busy", int'(busy), 0);

        // Collect every star in turn
        for (int s = 0; s < N; s++) begin
            char_X = 10'(sx_tbl[s]); char_Y = 10'(sy_tbl[s]);
            run_scan(np, pslot, pidx, bc);
            check($sformatf("all_s%0d_idx", s), pidx, s);
            if (s == N - 2) check("all_collected_before_last", int'(all_collected), 0);
        end
        check("all_collected_mask", int'(star_mask), 0);
        check("all_collected_flag", int'(all_collected), 1);
        check("all_collected_count", int'(star_count), N);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
